// File: rtl/mc_control.sv
// Multi-cycle MIPS-subset control FSM with memory wait timeout and a sticky trap state.
// Optional jal/jr support (link_wen port, JR dispatch) is enabled by defining MC_JAL_EN.
module mc_control #(
    parameter int unsigned WAIT_MAX = 15
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [5:0] op,
    input  logic [5:0] funct,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       pc_wen,
    output logic       ir_wen,
    output logic       iord,
    output logic       mem_ren,
    output logic       mem_wen,
    output logic       rf_wen,
    output logic       rf_dst,
    output logic       data_rf,
    output logic       alu_src_a,
    output logic [1:0] pc_src,
    output logic [1:0] alu_src_b,
    output logic [3:0] alu_op,
    output logic [3:0] state,
`ifdef MC_JAL_EN
    output logic       link_wen,
`endif
    output logic       trap
);

    localparam int unsigned CNT_W = 8;
    localparam logic [CNT_W-1:0] WAIT_LIM = CNT_W'(WAIT_MAX);

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] FN_JR  = 6'h08;
    localparam logic [5:0] FN_ADD = 6'h20;
    localparam logic [5:0] FN_SUB = 6'h22;
    localparam logic [5:0] FN_AND = 6'h24;
    localparam logic [5:0] FN_OR  = 6'h25;
    localparam logic [5:0] FN_SLT = 6'h2A;

    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_SLT = 4'b0111;

    typedef enum logic [3:0] {
        S_FETCH   = 4'd0,
        S_DECODE  = 4'd1,
        S_MEMADDR = 4'd2,
        S_MEMRD   = 4'd3,
        S_MEMWB   = 4'd4,
        S_MEMWR   = 4'd5,
        S_EXEC    = 4'd6,
        S_RWB     = 4'd7,
        S_BRANCH  = 4'd8,
        S_JUMP    = 4'd9,
        S_IEXEC   = 4'd10,
        S_IWB     = 4'd11,
        S_JR      = 4'd12,
        S_TRAP    = 4'd13
    } state_t;

    state_t           cur;
    state_t           nxt;
    logic [CNT_W-1:0] wait_cnt;
    logic             waiting;
    logic             timeout;
    logic [3:0]       exec_alu;
    logic             exec_legal;

    assign waiting = (cur == S_FETCH) || (cur == S_MEMRD) || (cur == S_MEMWR);
    assign timeout = (wait_cnt == WAIT_LIM);
    assign state   = cur;

    // R-type function decode
    always_comb begin
        exec_alu   = ALU_AND;
        exec_legal = 1'b1;
        case (funct)
            FN_ADD:  exec_alu = ALU_ADD;
            FN_SUB:  exec_alu = ALU_SUB;
            FN_AND:  exec_alu = ALU_AND;
            FN_OR:   exec_alu = ALU_OR;
            FN_SLT:  exec_alu = ALU_SLT;
            default: exec_legal = 1'b0;
        endcase
    end

    // Next-state logic; mem_ready wins over a same-cycle timeout
    always_comb begin
        nxt = cur;
        case (cur)
            S_FETCH: begin
                if (mem_ready)    nxt = S_DECODE;
                else if (timeout) nxt = S_TRAP;
            end
            S_DECODE: begin
                case (op)
                    OP_RTYPE: begin
`ifdef MC_JAL_EN
                        nxt = (funct == FN_JR) ? S_JR : S_EXEC;
`else
                        nxt = (funct == FN_JR) ? S_TRAP : S_EXEC;
`endif
                    end
                    OP_LW, OP_SW: nxt = S_MEMADDR;
                    OP_BEQ:       nxt = S_BRANCH;
                    OP_ADDI:      nxt = S_IEXEC;
                    OP_J:         nxt = S_JUMP;
`ifdef MC_JAL_EN
                    OP_JAL:       nxt = S_JUMP;
`endif
                    default:      nxt = S_TRAP;
                endcase
            end
            S_MEMADDR: begin
                if (op == OP_LW)      nxt = S_MEMRD;
                else if (op == OP_SW) nxt = S_MEMWR;
                else                  nxt = S_TRAP;
            end
            S_MEMRD: begin
                if (mem_ready)    nxt = S_MEMWB;
                else if (timeout) nxt = S_TRAP;
            end
            S_MEMWR: begin
                if (mem_ready)    nxt = S_FETCH;
                else if (timeout) nxt = S_TRAP;
            end
            S_EXEC:   nxt = exec_legal ? S_RWB : S_TRAP;
            S_IEXEC:  nxt = S_IWB;
            S_MEMWB, S_RWB, S_BRANCH, S_JUMP, S_IWB, S_JR: nxt = S_FETCH;
            S_TRAP:   nxt = S_TRAP;
            default:  nxt = S_TRAP;
        endcase
    end

    // State register and per-state wait counter, cleared whenever the state changes
    always_ff @(posedge clk) begin
        if (!rst) begin
            cur      <= S_FETCH;
            wait_cnt <= '0;
        end else begin
            cur <= nxt;
            if (nxt != cur || !waiting) wait_cnt <= '0;
            else                        wait_cnt <= wait_cnt + CNT_W'(1);
        end
    end

    // Output decode of the current state; everything is forced low while reset is held
    always_comb begin
        pc_wen    = 1'b0;
        ir_wen    = 1'b0;
        iord      = 1'b0;
        mem_ren   = 1'b0;
        mem_wen   = 1'b0;
        rf_wen    = 1'b0;
        rf_dst    = 1'b0;
        data_rf   = 1'b0;
        alu_src_a = 1'b0;
        pc_src    = 2'd0;
        alu_src_b = 2'd0;
        alu_op    = 4'd0;
        trap      = 1'b0;
`ifdef MC_JAL_EN
        link_wen  = 1'b0;
`endif
        if (rst) begin
            case (cur)
                S_FETCH: begin
                    mem_ren   = 1'b1;
                    alu_src_b = 2'd1;
                    alu_op    = ALU_ADD;
                    ir_wen    = mem_ready;
                    pc_wen    = mem_ready;
                end
                S_DECODE: begin
                    alu_src_b = 2'd3;
                    alu_op    = ALU_ADD;
                end
                S_MEMADDR, S_IEXEC: begin
                    alu_src_a = 1'b1;
                    alu_src_b = 2'd2;
                    alu_op    = ALU_ADD;
                end
                S_MEMRD: begin
                    iord    = 1'b1;
                    mem_ren = 1'b1;
                end
                S_MEMWR: begin
                    iord    = 1'b1;
                    mem_wen = 1'b1;
                end
                S_MEMWB: begin
                    rf_wen  = 1'b1;
                    data_rf = 1'b1;
                end
                S_EXEC: begin
                    alu_src_a = 1'b1;
                    alu_op    = exec_alu;
                end
                S_RWB: begin
                    rf_wen = 1'b1;
                    rf_dst = 1'b1;
                end
                S_BRANCH: begin
                    alu_src_a = 1'b1;
                    alu_op    = ALU_SUB;
                    pc_src    = 2'd1;
                    pc_wen    = zero;
                end
                S_JUMP: begin
                    pc_wen = 1'b1;
                    pc_src = 2'd2;
`ifdef MC_JAL_EN
                    link_wen = (op == OP_JAL);
`endif
                end
                S_IWB:  rf_wen = 1'b1;
                S_JR: begin
                    pc_wen = 1'b1;
                    pc_src = 2'd3;
                end
                S_TRAP:  trap = 1'b1;
                default: trap = 1'b0;
            endcase
        end
    end

endmodule

// File: tb/tb_mc_control.sv
// Self-checking bench for mc_control: directed vector table, hand-written corner
// sequences, and random instruction streams against an instruction-level model.
module tb_mc_control;

    localparam int unsigned WAIT_MAX = 5;
`ifdef MC_JAL_EN
    localparam bit JAL = 1'b1;
`else
    localparam bit JAL = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic [5:0] op;
    logic [5:0] funct;
    logic       zero;
    logic       mem_ready;
    logic       pc_wen, ir_wen, iord, mem_ren, mem_wen, rf_wen, rf_dst, data_rf, alu_src_a;
    logic [1:0] pc_src, alu_src_b;
    logic [3:0] alu_op;
    logic [3:0] state;
    logic       trap;
    logic       link_wen;

    always #5 clk = ~clk;

    mc_control #(.WAIT_MAX(WAIT_MAX)) dut (
        .clk(clk), .rst(rst), .op(op), .funct(funct), .zero(zero), .mem_ready(mem_ready),
        .pc_wen(pc_wen), .ir_wen(ir_wen), .iord(iord), .mem_ren(mem_ren), .mem_wen(mem_wen),
        .rf_wen(rf_wen), .rf_dst(rf_dst), .data_rf(data_rf), .alu_src_a(alu_src_a),
        .pc_src(pc_src), .alu_src_b(alu_src_b), .alu_op(alu_op), .state(state),
`ifdef MC_JAL_EN
        .link_wen(link_wen),
`endif
        .trap(trap)
    );
`ifndef MC_JAL_EN
    assign link_wen = 1'b0;
`endif

    typedef struct packed {
        logic       pc_wen, ir_wen, iord, mem_ren, mem_wen, rf_wen, rf_dst, data_rf, alu_src_a;
        logic [1:0] pc_src;
        logic [1:0] alu_src_b;
        logic [3:0] alu_op;
        logic       trap;
        logic       link_wen;
    } out_t;

    typedef struct {
        string      name;
        logic [5:0] op;
        logic [5:0] funct;
        logic       z;
        int         len;
        logic [31:0] seq;
    } vec_t;

    out_t act;
    assign act = {pc_wen, ir_wen, iord, mem_ren, mem_wen, rf_wen, rf_dst, data_rf, alu_src_a,
                  pc_src, alu_src_b, alu_op, trap, link_wen};

    int   n_chk = 0;
    int   n_fail = 0;
    vec_t vecs[$];
    logic [5:0] legal_f [5] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2A};

    task automatic chk(input string name, input int a, input int e);
        n_chk++;
        if (a !== e) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, a, e, $time);
        end
    endtask

    task automatic chk_out(input string name, input out_t a, input out_t e);
        n_chk++;
        if (a !== e) begin
            n_fail++;
            $display("FAIL %s: got outputs %b expected %b (t=%0t)", name, a, e, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        mem_ready = 1'b1;
        step();
        step();
        rst = 1'b1;
    endtask

    function automatic logic is_legal_funct(input logic [5:0] f);
        return f inside {6'h20, 6'h22, 6'h24, 6'h25, 6'h2A};
    endfunction

    // Control word each state must present, written from the state descriptions
    function automatic out_t exp_out(input int st, input logic mr, input logic z,
                                     input logic [5:0] o, input logic [5:0] f);
        out_t e;
        e = '0;
        case (st)
            0:  begin e.mem_ren = 1; e.alu_src_b = 2'd1; e.alu_op = 4'b0010;
                      e.pc_wen = mr; e.ir_wen = mr; end
            1:  begin e.alu_src_b = 2'd3; e.alu_op = 4'b0010; end
            2, 10: begin e.alu_src_a = 1; e.alu_src_b = 2'd2; e.alu_op = 4'b0010; end
            3:  begin e.iord = 1; e.mem_ren = 1; end
            4:  begin e.rf_wen = 1; e.data_rf = 1; end
            5:  begin e.iord = 1; e.mem_wen = 1; end
            6:  begin
                    e.alu_src_a = 1;
                    case (f)
                        6'h20:   e.alu_op = 4'b0010;
                        6'h22:   e.alu_op = 4'b0110;
                        6'h24:   e.alu_op = 4'b0000;
                        6'h25:   e.alu_op = 4'b0001;
                        6'h2A:   e.alu_op = 4'b0111;
                        default: e.alu_op = 4'b0000;
                    endcase
                end
            7:  begin e.rf_wen = 1; e.rf_dst = 1; end
            8:  begin e.alu_src_a = 1; e.alu_op = 4'b0110; e.pc_src = 2'd1; e.pc_wen = z; end
            9:  begin e.pc_wen = 1; e.pc_src = 2'd2; e.link_wen = JAL && (o == 6'h03); end
            11: e.rf_wen = 1;
            12: begin e.pc_wen = 1; e.pc_src = 2'd3; end
            13: e.trap = 1;
            default: e = '0;
        endcase
        return e;
    endfunction

    // Instruction-level path (state codes as hex digits, first = FETCH) with zero memory wait
    function automatic logic [31:0] path_for(input logic [5:0] o, input logic [5:0] f,
                                             output int len);
        len = 3;
        case (o)
            6'h23: begin len = 5; return 32'h01234; end
            6'h2B: begin len = 4; return 32'h0125; end
            6'h04: return 32'h018;
            6'h08: begin len = 4; return 32'h01AB; end
            6'h02: return 32'h019;
            6'h03: return JAL ? 32'h019 : 32'h01D;
            6'h00: begin
                if (f == 6'h08) return JAL ? 32'h01C : 32'h01D;
                len = 4;
                return is_legal_funct(f) ? 32'h0167 : 32'h016D;
            end
            default: return 32'h01D;
        endcase
    endfunction

    function automatic int nib(input logic [31:0] p, input int len, input int i);
        return int'(p[(len-1-i)*4 +: 4]);
    endfunction

    task automatic run_vectors();
        foreach (vecs[v]) begin
            do_reset();
            op = vecs[v].op;
            funct = vecs[v].funct;
            zero = vecs[v].z;
            mem_ready = 1'b1;
            for (int i = 0; i < vecs[v].len; i++) begin
                #1;
                chk({vecs[v].name, " state"}, int'(state), nib(vecs[v].seq, vecs[v].len, i));
                chk_out({vecs[v].name, " outputs"}, act,
                        exp_out(nib(vecs[v].seq, vecs[v].len, i), 1'b1, zero, op, funct));
                step();
            end
        end
    endtask

    task automatic run_random(input int n_instr);
        logic [31:0] p;
        int len, idx, waited, exp_st;
        bit stall, done;
        do_reset();
        for (int n = 0; n < n_instr; n++) begin
            funct = 6'($urandom);
            case ($urandom_range(0, 9))
                0: op = 6'h23;
                1: op = 6'h2B;
                2: op = 6'h04;
                3: op = 6'h08;
                4: op = 6'h02;
                5: op = 6'h03;
                6: begin op = 6'h00; funct = legal_f[$urandom_range(0, 4)]; end
                7: op = 6'h00;
                8: begin op = 6'h00; funct = 6'h08; end
                default: op = 6'($urandom);
            endcase
            p = path_for(op, funct, len);
            stall = ($urandom_range(0, 11) == 0);
            idx = 0; waited = 0; exp_st = 0; done = 0;
            for (int c = 0; c < 200 && !done; c++) begin
                mem_ready = stall ? 1'b0 : ($urandom_range(0, 3) != 0);
                zero = 1'($urandom);
                #1;
                chk("rand state", int'(state), exp_st);
                chk_out("rand outputs", act, exp_out(exp_st, mem_ready, zero, op, funct));
                if (exp_st == 13) begin
                    rst = 1'b0;
                    step();
                    rst = 1'b1;
                    done = 1;
                end else begin
                    if ((exp_st == 0 || exp_st == 3 || exp_st == 5) && !mem_ready) begin
                        if (waited == int'(WAIT_MAX)) exp_st = 13;
                        else waited++;
                    end else begin
                        idx++;
                        waited = 0;
                        if (idx == len) done = 1;
                        else exp_st = nib(p, len, idx);
                    end
                    step();
                end
            end
            if (!done) begin
                n_chk++;
                n_fail++;
                $display("FAIL rand watchdog: instruction %0d never completed", n);
                do_reset();
            end
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b0; op = 6'h23; funct = 6'h00; zero = 1'b0; mem_ready = 1'b1;

        vecs.push_back('{"lw",       6'h23, 6'h00, 1'b1, 6, 32'h012340});
        vecs.push_back('{"sw",       6'h2B, 6'h00, 1'b1, 5, 32'h01250});
        vecs.push_back('{"beq z1",   6'h04, 6'h00, 1'b1, 4, 32'h0180});
        vecs.push_back('{"beq z0",   6'h04, 6'h00, 1'b0, 4, 32'h0180});
        vecs.push_back('{"addi",     6'h08, 6'h00, 1'b0, 5, 32'h01AB0});
        vecs.push_back('{"j",        6'h02, 6'h00, 1'b0, 4, 32'h0190});
        vecs.push_back('{"add",      6'h00, 6'h20, 1'b0, 5, 32'h01670});
        vecs.push_back('{"sub",      6'h00, 6'h22, 1'b0, 5, 32'h01670});
        vecs.push_back('{"and",      6'h00, 6'h24, 1'b0, 5, 32'h01670});
        vecs.push_back('{"or",       6'h00, 6'h25, 1'b0, 5, 32'h01670});
        vecs.push_back('{"slt",      6'h00, 6'h2A, 1'b0, 5, 32'h01670});
        vecs.push_back('{"bad funct", 6'h00, 6'h3F, 1'b0, 5, 32'h016DD});
        vecs.push_back('{"bad op",   6'h3F, 6'h00, 1'b0, 4, 32'h01DD});
`ifdef MC_JAL_EN
        vecs.push_back('{"jal",      6'h03, 6'h00, 1'b0, 4, 32'h0190});
        vecs.push_back('{"jr",       6'h00, 6'h08, 1'b0, 4, 32'h01C0});
`else
        vecs.push_back('{"jal",      6'h03, 6'h00, 1'b0, 4, 32'h01DD});
        vecs.push_back('{"jr",       6'h00, 6'h08, 1'b0, 4, 32'h01DD});
`endif

        // Reset held two cycles with mem_ready high
        step();
        step();
        #1;
        chk("reset state", int'(state), 0);
        chk_out("reset outputs", act, out_t'(0));
        rst = 1'b1;
        #1;
        chk_out("first fetch outputs", act, exp_out(0, 1'b1, zero, op, funct));
        step();

        run_vectors();

        // sw stalled in MEMWR for WAIT_MAX+1 cycles traps; reset recovers
        do_reset();
        op = 6'h2B; funct = 6'h00; mem_ready = 1'b1;
        step(); step(); step();
        mem_ready = 1'b0;
        for (int k = 0; k <= int'(WAIT_MAX); k++) begin
            #1;
            chk("sw wait state", int'(state), 5);
            chk_out("sw wait outputs", act, exp_out(5, 1'b0, zero, op, funct));
            step();
        end
        #1;
        chk("sw timeout state", int'(state), 13);
        chk_out("sw timeout outputs", act, exp_out(13, 1'b0, zero, op, funct));
        step();
        mem_ready = 1'b1;
        #1;
        chk("trap sticky state", int'(state), 13);
        chk("trap sticky mem_wen", int'(mem_wen), 0);
        rst = 1'b0;
        step();
        chk("trap reset state", int'(state), 0);
        chk("trap reset trap", int'(trap), 0);
        rst = 1'b1;

        // lw: mem_ready arrives on the last allowed wait cycle and wins over timeout
        do_reset();
        op = 6'h23; mem_ready = 1'b1;
        step(); step(); step();
        mem_ready = 1'b0;
        for (int k = 0; k < int'(WAIT_MAX); k++) begin
            #1;
            chk("lw wait state", int'(state), 3);
            step();
        end
        mem_ready = 1'b1;
        #1;
        chk("lw late ready state", int'(state), 3);
        step();
        chk("lw late ready wb state", int'(state), 4);
        chk_out("lw late ready wb outputs", act, exp_out(4, 1'b1, zero, op, funct));

        // FETCH timeout
        do_reset();
        mem_ready = 1'b0;
        for (int k = 0; k <= int'(WAIT_MAX); k++) begin
            #1;
            chk("fetch wait state", int'(state), 0);
            chk("fetch wait ir_wen", int'(ir_wen), 0);
            step();
        end
        chk("fetch timeout state", int'(state), 13);

        // Reset during a stalled lw read: back to FETCH with no register write
        do_reset();
        op = 6'h23; mem_ready = 1'b1;
        step(); step(); step();
        mem_ready = 1'b0;
        #1;
        chk("memrd stall state", int'(state), 3);
        rst = 1'b0;
        #1;
        chk_out("memrd reset outputs", act, out_t'(0));
        step();
        chk("memrd reset state", int'(state), 0);
        chk("memrd reset rf_wen", int'(rf_wen), 0);
        rst = 1'b1;
        #1;
        chk("memrd release rf_wen", int'(rf_wen), 0);
        chk_out("memrd release outputs", act, exp_out(0, 1'b0, zero, op, funct));
        step();

        run_random(200);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
